// File: rtl/rf_scoreboard.sv
// Per-GPR in-flight writer/load counters that gate decode issue with a load-use stall; updates land next clk edge.
// Stall/ready are combinational from registered counters only; optional SCOREBOARD_PERF_EN adds perf_stall_cnt.
module rf_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     issue_gr_we,
    input  logic                     issue_is_load,
    input  logic [$clog2(NREG)-1:0]  issue_dest,
    input  logic                     issue_rj_rd,
    input  logic [$clog2(NREG)-1:0]  issue_rj,
    input  logic                     issue_rkd_rd,
    input  logic [$clog2(NREG)-1:0]  issue_rkd,
    input  logic                     ld_ready_valid,
    input  logic [$clog2(NREG)-1:0]  ld_ready_dest,
    input  logic                     wb_valid,
    input  logic                     wb_we,
    input  logic [$clog2(NREG)-1:0]  wb_dest,
    input  logic                     flush,
    output logic [NREG-1:0]          busy_mask,
    output logic                     stall_rj,
    output logic                     stall_rkd,
    output logic                     err
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic            w_issue_fire;
    logic [NREG-1:0] w_wr_nz;
    logic [NREG-1:0] w_ld_nz;
    logic [NREG-1:0] w_err_evt;
    logic            r_err;

    // Returns {error, next}: saturating +1/-1 step, opposing events cancel.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
        logic [CNT_W:0] res;
        res = {1'b0, c};
        if (inc && !dec) begin
            if (c == CNT_MAX) res = {1'b1, c};
            else              res = {1'b0, c + 1'b1};
        end else if (dec && !inc) begin
            if (c == '0) res = {1'b1, c};
            else         res = {1'b0, c - 1'b1};
        end
        return res;
    endfunction

    assign w_wr_nz[0]   = 1'b0;
    assign w_ld_nz[0]   = 1'b0;
    assign w_err_evt[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [CNT_W-1:0] r_wr_cnt;
        logic [CNT_W-1:0] r_ld_cnt;
        logic             w_wr_inc;
        logic             w_wr_dec;
        logic             w_ld_inc;
        logic             w_ld_dec;
        logic [CNT_W:0]   w_wr_upd;
        logic [CNT_W:0]   w_ld_upd;

        assign w_wr_inc = w_issue_fire & issue_gr_we & (issue_dest == IDX_W'(i));
        assign w_ld_inc = w_wr_inc & issue_is_load;
        assign w_wr_dec = wb_valid & wb_we & (wb_dest == IDX_W'(i));
        assign w_ld_dec = ld_ready_valid & (ld_ready_dest == IDX_W'(i));
        assign w_wr_upd = cnt_step(r_wr_cnt, w_wr_inc, w_wr_dec);
        assign w_ld_upd = cnt_step(r_ld_cnt, w_ld_inc, w_ld_dec);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_wr_cnt <= '0;
                r_ld_cnt <= '0;
            end else if (flush) begin
                r_wr_cnt <= '0;
                r_ld_cnt <= '0;
            end else begin
                r_wr_cnt <= w_wr_upd[CNT_W-1:0];
                r_ld_cnt <= w_ld_upd[CNT_W-1:0];
            end
        end

        assign w_wr_nz[i]   = |r_wr_cnt;
        assign w_ld_nz[i]   = |r_ld_cnt;
        assign w_err_evt[i] = w_wr_upd[CNT_W] | w_ld_upd[CNT_W];
    end

    // Register 0 is never tracked, so its nonzero bits are constant 0.
    assign stall_rj     = issue_valid & issue_rj_rd  & w_ld_nz[issue_rj];
    assign stall_rkd    = issue_valid & issue_rkd_rd & w_ld_nz[issue_rkd];
    assign issue_ready  = ~(stall_rj | stall_rkd);
    assign w_issue_fire = issue_valid & issue_ready & ~flush;
    assign busy_mask    = w_wr_nz;
    assign err          = r_err;

    // Flush discards every same-cycle event, including ones that would overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_err <= 1'b0;
        else         r_err <= r_err | (~flush & (|w_err_evt));
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         r_perf_stall_cnt <= '0;
        else if (issue_valid && !issue_ready) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
